// File: rtl/pipeline_processor_p.sv
// Five-stage in-order core (IF/ID/EX/MEM/WB) with full forwarding, load-use stall,
// run-control FSM with HALT draining, and a program/data load port.
module pipeline_processor_p #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1,
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1,
  localparam int AW  = (IAW > DAW) ? IAW : DAW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic              prog_sel,
  input  logic [AW-1:0]     prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              start,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              halted,
  output logic              busy
);
  localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                         OP_XOR = 4'd5, OP_LDI = 4'd6, OP_LD = 4'd7, OP_ST = 4'd8,
                         OP_HALT = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic uses_rs1(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_XOR) || op == OP_LD || op == OP_ST;
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_XOR) || op == OP_ST;
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_LD;
  endfunction

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] rf_reg [8];

  state_t            state_reg;
  logic [IAW-1:0]    pc_reg;
  logic              ifid_valid_reg;
  logic [15:0]       ifid_instr_reg;
  logic              idex_valid_reg;
  logic [3:0]        idex_op_reg;
  logic [2:0]        idex_rd_reg, idex_rs1_reg, idex_rs2_reg;
  logic [DATA_W-1:0] idex_a_reg, idex_b_reg;
  logic [7:0]        idex_imm_reg;
  logic              exmem_valid_reg, exmem_wr_reg, exmem_ld_reg, exmem_st_reg, exmem_halt_reg;
  logic [2:0]        exmem_rd_reg;
  logic [DATA_W-1:0] exmem_alu_reg, exmem_sdata_reg;
  logic [DAW-1:0]    exmem_addr_reg;
  logic              memwb_valid_reg, memwb_wr_reg, memwb_ld_reg, memwb_halt_reg;
  logic [2:0]        memwb_rd_reg;
  logic [DATA_W-1:0] memwb_alu_reg, memwb_ldata_reg;
  logic [DATA_W-1:0] result_reg;
  logic              result_valid_reg;

  logic              can_load, run_active;
  logic [15:0]       fetch_word;
  logic [3:0]        id_op;
  logic [2:0]        id_rd, id_rs1, id_rs2;
  logic [DATA_W-1:0] id_a, id_b, wb_data, ex_a, ex_b, ex_alu, dm_wdata;
  logic              wb_wr, id_halt, stall, dm_we;
  logic [DAW-1:0]    dm_waddr;
  logic              unused_ok;

  assign can_load   = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign run_active = (state_reg == S_RUN) || (state_reg == S_DRAIN);
  assign fetch_word = imem[pc_reg];
  assign unused_ok  = ^{ifid_instr_reg[11], prog_addr};

  assign id_op  = ifid_instr_reg[15:12];
  assign id_rd  = ifid_instr_reg[10:8];
  assign id_rs1 = ifid_instr_reg[6:4];
  assign id_rs2 = ifid_instr_reg[2:0];

  // WB writes the register file at the end of the cycle, so ID bypasses it.
  assign wb_wr   = memwb_valid_reg && memwb_wr_reg;
  assign wb_data = memwb_ld_reg ? memwb_ldata_reg : memwb_alu_reg;
  assign id_a    = (wb_wr && memwb_rd_reg == id_rs1) ? wb_data : rf_reg[id_rs1];
  assign id_b    = (wb_wr && memwb_rd_reg == id_rs2) ? wb_data : rf_reg[id_rs2];
  assign id_halt = ifid_valid_reg && id_op == OP_HALT;

  assign stall = ifid_valid_reg && idex_valid_reg && idex_op_reg == OP_LD && idex_rd_reg != 3'd0 &&
                 ((uses_rs1(id_op) && id_rs1 == idex_rd_reg) || (uses_rs2(id_op) && id_rs2 == idex_rd_reg));

  // Load data is not ready in MEM; the stall guarantees no consumer needs it there.
  always_comb begin
    ex_a = idex_a_reg;
    ex_b = idex_b_reg;
    if (exmem_valid_reg && exmem_wr_reg && !exmem_ld_reg && exmem_rd_reg == idex_rs1_reg)
      ex_a = exmem_alu_reg;
    else if (wb_wr && memwb_rd_reg == idex_rs1_reg)
      ex_a = wb_data;
    if (exmem_valid_reg && exmem_wr_reg && !exmem_ld_reg && exmem_rd_reg == idex_rs2_reg)
      ex_b = exmem_alu_reg;
    else if (wb_wr && memwb_rd_reg == idex_rs2_reg)
      ex_b = wb_data;
  end

  always_comb begin
    ex_alu = '0;
    case (idex_op_reg)
      OP_ADD:  ex_alu = ex_a + ex_b;
      OP_SUB:  ex_alu = ex_a - ex_b;
      OP_AND:  ex_alu = ex_a & ex_b;
      OP_OR:   ex_alu = ex_a | ex_b;
      OP_XOR:  ex_alu = ex_a ^ ex_b;
      OP_LDI:  ex_alu = DATA_W'(idex_imm_reg);
      default: ex_alu = '0;
    endcase
  end

  always_comb begin
    dm_we    = 1'b0;
    dm_waddr = prog_addr[DAW-1:0];
    dm_wdata = DATA_W'(prog_data);
    if (exmem_valid_reg && exmem_st_reg) begin
      dm_we    = 1'b1;
      dm_waddr = exmem_addr_reg;
      dm_wdata = exmem_sdata_reg;
    end else if (can_load && prog_we && prog_sel) begin
      dm_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (can_load && prog_we && !prog_sel)
      imem[prog_addr[IAW-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (dm_we)
      dmem[dm_waddr] <= dm_wdata;
    memwb_ldata_reg <= dmem[exmem_addr_reg];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      pc_reg           <= '0;
      ifid_valid_reg   <= 1'b0;
      ifid_instr_reg   <= '0;
      idex_valid_reg   <= 1'b0;
      idex_op_reg      <= '0;
      idex_rd_reg      <= '0;
      idex_rs1_reg     <= '0;
      idex_rs2_reg     <= '0;
      idex_a_reg       <= '0;
      idex_b_reg       <= '0;
      idex_imm_reg     <= '0;
      exmem_valid_reg  <= 1'b0;
      exmem_wr_reg     <= 1'b0;
      exmem_ld_reg     <= 1'b0;
      exmem_st_reg     <= 1'b0;
      exmem_halt_reg   <= 1'b0;
      exmem_rd_reg     <= '0;
      exmem_alu_reg    <= '0;
      exmem_sdata_reg  <= '0;
      exmem_addr_reg   <= '0;
      memwb_valid_reg  <= 1'b0;
      memwb_wr_reg     <= 1'b0;
      memwb_ld_reg     <= 1'b0;
      memwb_halt_reg   <= 1'b0;
      memwb_rd_reg     <= '0;
      memwb_alu_reg    <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE, S_DONE: if (start) begin
          state_reg       <= S_RUN;
          pc_reg          <= '0;
          ifid_valid_reg  <= 1'b0;
          idex_valid_reg  <= 1'b0;
          exmem_valid_reg <= 1'b0;
          memwb_valid_reg <= 1'b0;
          for (int i = 0; i < 8; i++) rf_reg[i] <= '0;
        end
        S_RUN:   if (id_halt) state_reg <= S_DRAIN;
        S_DRAIN: if (memwb_valid_reg && memwb_halt_reg) state_reg <= S_DONE;
        default: state_reg <= S_IDLE;
      endcase

      if (run_active) begin
        if (wb_wr) begin
          rf_reg[memwb_rd_reg] <= wb_data;
          result_reg           <= wb_data;
          result_valid_reg     <= 1'b1;
        end
        memwb_valid_reg <= exmem_valid_reg;
        memwb_wr_reg    <= exmem_wr_reg;
        memwb_ld_reg    <= exmem_ld_reg;
        memwb_halt_reg  <= exmem_halt_reg;
        memwb_rd_reg    <= exmem_rd_reg;
        memwb_alu_reg   <= exmem_alu_reg;

        exmem_valid_reg <= idex_valid_reg;
        exmem_wr_reg    <= writes_rd(idex_op_reg) && idex_rd_reg != 3'd0;
        exmem_ld_reg    <= idex_op_reg == OP_LD;
        exmem_st_reg    <= idex_op_reg == OP_ST;
        exmem_halt_reg  <= idex_op_reg == OP_HALT;
        exmem_rd_reg    <= idex_rd_reg;
        exmem_alu_reg   <= ex_alu;
        exmem_addr_reg  <= DAW'(ex_a);
        exmem_sdata_reg <= ex_b;

        if (stall) begin
          idex_valid_reg <= 1'b0;
        end else begin
          idex_valid_reg <= ifid_valid_reg;
          idex_op_reg    <= id_op;
          idex_rd_reg    <= id_rd;
          idex_rs1_reg   <= id_rs1;
          idex_rs2_reg   <= id_rs2;
          idex_a_reg     <= id_a;
          idex_b_reg     <= id_b;
          idex_imm_reg   <= ifid_instr_reg[7:0];
          // A HALT reaching ID squashes the word in IF and freezes the PC.
          if (state_reg == S_RUN && !id_halt) begin
            ifid_valid_reg <= 1'b1;
            ifid_instr_reg <= fetch_word;
            pc_reg         <= pc_reg + IAW'(1);
          end else begin
            ifid_valid_reg <= 1'b0;
          end
        end
      end
    end
  end

  assign result       = result_reg;
  assign result_valid = result_valid_reg;
  assign halted       = state_reg == S_DONE;
  assign busy         = run_active;
endmodule

// File: tb/tb_pipeline_processor_p.sv
// Scoreboard bench: an ISA-level model predicts each writeback value and its cycle;
// a negedge monitor pops and compares whenever result_valid pulses.
module tb_pipeline_processor_p;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          prog_we = 1'b0, prog_sel = 1'b0, start = 1'b0;
  logic [3:0]    prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic [DW-1:0] result;
  logic          result_valid, halted, busy;

  pipeline_processor_p #(.DATA_W(DW), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_sel(prog_sel),
    .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
    .result(result), .result_valid(result_valid), .halted(halted), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] val; int at; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] im_m [16];
  int          dm_m [16];

  always @(negedge clk) begin
    exp_t e;
    if (result_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse: unexpected result 0x%02h at cycle %0d", result, cyc);
      end else begin
        e = sb.pop_front();
        if (result !== e.val || cyc != e.at) begin
          errors++;
          $display("FAIL pulse: got 0x%02h at cycle %0d, want 0x%02h at cycle %0d", result, cyc, e.val, e.at);
        end else begin
          $display("txn result=0x%02h cycle=%0d", result, cyc);
        end
      end
    end
  end

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {op[3:0], 1'b0, rd[2:0], 1'b0, rs1[2:0], 1'b0, rs2[2:0]};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'd6, 1'b0, rd[2:0], imm[7:0]};
  endfunction

  task automatic load(input logic sel, input int addr, input logic [15:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_sel = sel; prog_addr = addr[3:0]; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
    if (!sel) im_m[addr] = data;
    else      dm_m[addr] = int'(data[7:0]);
  endtask

  // Executes the program one instruction at a time; each instruction occupies one
  // issue slot, plus one extra slot when it consumes the register loaded just before it.
  task automatic model(input int e0, input int limit, output int halt_at);
    int regs[8];
    int pc, slot, prev_ld, op, rd, a, b, va, vb, v;
    logic [15:0] w;
    logic use_a, use_b;
    for (int i = 0; i < 8; i++) regs[i] = 0;
    pc = 0; slot = 0; prev_ld = 0; halt_at = -1;
    for (int k = 0; k < 64; k++) begin
      w = im_m[pc];
      op = int'(w[15:12]); rd = int'(w[10:8]); a = int'(w[6:4]); b = int'(w[2:0]);
      use_a = op inside {[1:5], 7, 8};
      use_b = op inside {[1:5], 8};
      if (prev_ld != 0 && ((use_a && a == prev_ld) || (use_b && b == prev_ld))) slot++;
      prev_ld = (op == 7 && rd != 0) ? rd : 0;
      va = regs[a]; vb = regs[b]; v = 0;
      case (op)
        1: v = (va + vb) % 256;
        2: v = (va - vb + 256) % 256;
        3: v = va & vb;
        4: v = va | vb;
        5: v = va ^ vb;
        6: v = int'(w[7:0]);
        7: v = dm_m[va % 16];
        8: dm_m[va % 16] = vb;
        default: v = 0;
      endcase
      if (op >= 1 && op <= 7 && rd != 0) begin
        regs[rd] = v;
        if (e0 + 5 + slot <= limit) sb.push_back('{v[7:0], e0 + 5 + slot});
      end
      if (op == 15) begin
        halt_at = e0 + 5 + slot;
        break;
      end
      slot++;
      pc = (pc + 1) % 16;
    end
  endtask

  task automatic run_prog(input string name, input bit poke, input int rst_at);
    int e0, halt_at, n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    model(e0, (rst_at < 0) ? (1 << 30) : e0 + rst_at, halt_at);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on %s: busy=%b, want 1", name, busy);
    end
    if (poke) begin
      // Loads and start while running must be ignored.
      start = 1'b1; prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 4'd0; prog_data = ldi(5, 'h99);
      @(negedge clk);
      prog_sel = 1'b1;
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
    end
    if (rst_at < 0) begin
      n = 0;
      while (halted !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (halted !== 1'b1 || cyc != halt_at) begin
        errors++;
        $display("FAIL halt_time %s: halted=%b at cycle %0d, want 1 at cycle %0d", name, halted, cyc, halt_at);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_off %s: busy=%b, want 0", name, busy);
      end
    end else begin
      while (cyc < e0 + rst_at) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({result, result_valid, halted, busy} !== '0) begin
        errors++;
        $display("FAIL reset_out %s: result=0x%02h valid=%b halted=%b busy=%b, want all 0",
                 name, result, result_valid, halted, busy);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %s: %0d expected pulses missing, want 0", name, sb.size());
    end
    sb.delete();
    $display("prog %s finished at cycle %0d", name, cyc);
  endtask

  initial begin
    logic [15:0] w;
    int op;
    repeat (3) @(negedge clk);
    checks++;
    if ({result, result_valid, halted, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: result=0x%02h valid=%b halted=%b busy=%b, want all 0", result, result_valid, halted, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({halted, busy} !== 2'b00) begin
      errors++;
      $display("FAIL idle_state: halted=%b busy=%b, want 0 0", halted, busy);
    end

    load(0, 0, ldi(1, 5)); load(0, 1, ldi(2, 3)); load(0, 2, enc(1, 3, 1, 2)); load(0, 3, enc(15, 0, 0, 0));
    run_prog("forward", 1'b0, -1);

    load(1, 4, 16'd10);
    load(0, 0, ldi(1, 4)); load(0, 1, enc(7, 2, 1, 0)); load(0, 2, enc(1, 3, 2, 2)); load(0, 3, enc(15, 0, 0, 0));
    run_prog("load_use", 1'b0, -1);

    load(0, 0, ldi(1, 3)); load(0, 1, ldi(2, 5)); load(0, 2, enc(2, 3, 1, 2)); load(0, 3, enc(5, 4, 3, 3));
    load(0, 4, enc(15, 0, 0, 0));
    run_prog("wrap_sub", 1'b0, -1);

    load(0, 0, ldi(1, 7)); load(0, 1, ldi(2, 'h55)); load(0, 2, enc(8, 0, 1, 2)); load(0, 3, enc(7, 3, 1, 0));
    load(0, 4, enc(15, 0, 0, 0));
    run_prog("st_ld", 1'b0, -1);

    load(0, 0, ldi(0, 9)); load(0, 1, enc(1, 1, 0, 0)); load(0, 2, enc(15, 0, 0, 0));
    run_prog("r0_lockout", 1'b1, -1);
    run_prog("r0_rerun", 1'b0, -1);

    load(0, 0, ldi(1, 1)); load(0, 1, ldi(2, 2)); load(0, 2, enc(1, 3, 1, 2)); load(0, 3, enc(1, 4, 3, 3));
    load(0, 4, enc(15, 0, 0, 0));
    run_prog("reset_mid", 1'b0, 6);
    run_prog("reset_rerun", 1'b0, -1);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) load(1, i, 16'($urandom));
      for (int i = 0; i < 15; i++) begin
        op = int'($urandom_range(0, 9));
        if (op == 9) op = int'($urandom_range(9, 14));
        w = 16'($urandom);
        w[15:12] = op[3:0];
        load(0, i, w);
      end
      load(0, 15, enc(15, 0, 0, 0));
      run_prog($sformatf("random%0d", p), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/pipeline_processor_p.md
# pipeline_processor_p

Parametrised five-stage (IF/ID/EX/MEM/WB) in-order processor, successor to the fixed 8-bit `pipeline_processor`. It adds:
- configurable data width and memory depths;
- a 16-bit ISA with immediate load, load and store;
- full operand forwarding and a one-cycle load-use stall;
- a run-control FSM with HALT draining;
- a program/data load port, so benches no longer write internal memories hierarchically.

It is the core execution block of the task design; `result` reports every register writeback.

## Interface
- `DATA_W`, 8: register/ALU/data-memory width; must be ≥ 1.
- `IMEM_DEPTH`, 16: instruction words; power of two.
- `DMEM_DEPTH`, 16: data words; power of two.
- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `prog_we`  in  1  load strobe; honoured only in IDLE or DONE.
- `prog_sel`  in  1  0 = instruction memory, 1 = data memory.
- `prog_addr`  in  max(clog2(IMEM_DEPTH),clog2(DMEM_DEPTH))  load address; upper bits unused by the smaller memory.
- `prog_data`  in  16  load word; data memory takes bits `[DATA_W-1:0]`.
- `start`  in  1  begin execution at PC 0; honoured only in IDLE or DONE.
- `result`  out  DATA_W  value of the most recent register writeback.
- `result_valid`  out  1  one-cycle pulse per register writeback.
- `halted`  out  1  high in DONE.
- `busy`  out  1  high in RUN or DRAIN.

## Operation
- ISA, 16-bit words:
  - fields: `op[15:12]`, `rd[10:8]`, `rs1[6:4]`, `rs2[2:0]`, `imm8[7:0]`.
  - 0 NOP; 1 ADD; 2 SUB; 3 AND; 4 OR; 5 XOR: each computes `rd = rs1 op rs2`.
  - 6 LDI: `rd = imm8`, zero-extended, or truncated when DATA_W < 8.
  - 7 LD: `rd = DMEM[rs1 mod DMEM_DEPTH]`.
  - 8 ST: `DMEM[rs1 mod DMEM_DEPTH] = rs2`.
  - 15 HALT.
  - Opcodes 9–14 execute as NOP.
- Register file: 8 × DATA_W.
  - R0 always reads 0.
  - Writes to R0 are dropped and produce no `result_valid`.
- Arithmetic is modulo 2^DATA_W; carry and borrow are discarded.
- Memories:
  - Instruction memory is read combinationally from the PC in IF.
  - Data memory writes at the clock edge ending MEM.
  - Data memory reads are synchronous in MEM; data is used in WB.
  - Neither memory is cleared by reset.
- Forwarding: EX operands come from MEM (ALU result) first, then WB (ALU or load data), then the register file. R0 is never forwarded.
- Load-use hazard: a LD in EX whose `rd` (≠ R0) matches an ID source register causes a one-cycle stall. PC and IF/ID are held, and a bubble is inserted into EX.
- ST reads rs2 as a source register; ST and NOP never write a register.
- The PC increments modulo IMEM_DEPTH, so fetch wraps silently.
- FSM:
  - IDLE: reset state; loads allowed.
  - IDLE → RUN on `start`: PC = 0, pipeline cleared, registers cleared.
  - RUN → DRAIN when HALT is in ID. Fetch stops and the instruction in IF is squashed.
  - DRAIN → DONE when HALT leaves WB.
  - DONE → RUN on `start`, with the same clearing as from IDLE.
- `start` in RUN or DRAIN is ignored; `prog_we` in RUN or DRAIN is ignored.
- `prog_we` and `start` in the same cycle: the write completes first and execution starts next cycle with the new contents.

## Timing
- Reset state, asynchronous: FSM IDLE, PC 0, all pipeline valid bits 0, registers 0. `result` = 0, `result_valid` = 0, `halted` = 0, `busy` = 0.
- Reset mid-operation aborts immediately. No partial store completes after reset asserts.
- `start` sampled at edge E → instruction 0 is in IF during the cycle after E. `busy` is high from that cycle.
- With no stalls, instruction k (0-based) has `result_valid` high in cycle E+6+k. Outputs are registered at the WB edge.
- Each load-use stall adds one cycle to every later instruction.
- Back-to-back dependent ALU operations need no stall.
- A ST followed immediately by a LD to the same address returns the stored value.
- HALT fetched in cycle F: `halted` rises in cycle F+5 and `busy` falls in the same cycle.

## Test plan
- Forwarding: program LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT. Required: `result` pulses 5, 3, 8 on consecutive cycles starting E+6; `halted` high at E+9.
- Load-use stall: DMEM[4]=10; program LDI R1,4; LD R2,[R1]; ADD R3,R2,R2. Required: pulses 4, 10, then a one-cycle gap, then 20.
- Wrap-around arithmetic: LDI R1,3; LDI R2,5; SUB R3,R1,R2. Required: result 8'hFE. XOR R4,R3,R3 → 0.
- Store/load ordering: LDI R1,7; LDI R2,0x55; ST [R1],R2; LD R3,[R1]. Required: pulses 7, 0x55, a one-cycle gap for ST, then 0x55.
- R0 and lockout: LDI R0,9 produces no pulse; ADD R1,R0,R0 → 0. A `prog_we` issued during RUN leaves memory unchanged (verify on rerun).
- Reset mid-run: assert `reset` during the third instruction. Required: all outputs 0 and state IDLE. A fresh `start` reproduces the identical `result` sequence because the memories are retained.
